// File: rtl/memctrl_pkg.sv
// memctrl_pkg: size/cmd encodings, controller states and beat-count helper
package memctrl_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    typedef enum logic [1:0] {IDLE, REQ, GAP, RESP} state_t;

    // Index of the final beat; size 2'b11 is treated as a word.
    function automatic logic [1:0] last_beat(input logic [1:0] size);
        return size == SZ_B ? 2'd0 : size == SZ_H ? 2'd1 : 2'd3;
    endfunction

endpackage

// File: rtl/memctrl_if.sv
// memctrl_if: CPU-side command bus plus byte-wide external memory bus
interface memctrl_if;

    logic        en;
    logic        cmd;
    logic [1:0]  size;
    logic [31:0] ad;
    logic [31:0] din;
    logic [31:0] dout;
    logic        ready;
    logic        err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_ad;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        output en, cmd, size, ad, din, mem_rdata, mem_ack,
        input  dout, ready, err, busy, mem_req, mem_we, mem_ad, mem_wdata
    );

    modport slave (
        input  en, cmd, size, ad, din, mem_rdata, mem_ack,
        output dout, ready, err, busy, mem_req, mem_we, mem_ad, mem_wdata
    );

endinterface

// File: rtl/memctrl.sv
// memctrl: serialises byte/half/word CPU commands into byte beats on a req/ack memory bus
module memctrl
    import memctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input logic        clk,
    input logic        rst,
    memctrl_if.slave   bus
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(ACK_TIMEOUT);

    state_t          state_q, state_d;
    logic            cmd_q, cmd_d;
    logic [1:0]      last_q, last_d;
    logic [1:0]      k_q, k_d;
    logic [31:0]     ad_q, ad_d;
    logic [31:0]     din_q, din_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [31:0]     dout_q, dout_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_ad_q, mem_ad_d;
    logic [7:0]      mem_wdata_q, mem_wdata_d;

    assign bus.dout      = dout_q;
    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_ad    = mem_ad_q;
    assign bus.mem_wdata = mem_wdata_q;

    // State and registered outputs; reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= CMD_RD;
            last_q      <= '0;
            k_q         <= '0;
            ad_q        <= '0;
            din_q       <= '0;
            to_q        <= '0;
            dout_q      <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_ad_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            last_q      <= last_d;
            k_q         <= k_d;
            ad_q        <= ad_d;
            din_q       <= din_d;
            to_q        <= to_d;
            dout_q      <= dout_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_ad_q    <= mem_ad_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state, beat bookkeeping and the output values for the coming cycle.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        last_d      = last_q;
        k_d         = k_q;
        ad_d        = ad_q;
        din_d       = din_q;
        to_d        = '0;
        dout_d      = dout_q;
        err_d       = 1'b0;
        mem_ad_d    = mem_ad_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = REQ;
                    cmd_d   = bus.cmd;
                    last_d  = last_beat(bus.size);
                    ad_d    = bus.ad;
                    k_d     = '0;
                    if (bus.cmd == CMD_WR) din_d = bus.din;
                    if (bus.cmd == CMD_RD) dout_d = '0;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    if (cmd_q == CMD_RD) dout_d[{k_q, 3'b000} +: 8] = bus.mem_rdata;
                    k_d     = k_q + 2'd1;
                    state_d = k_q == last_q ? RESP : GAP;
                end else if (ACK_TIMEOUT != 0 && to_q + 1'b1 == TO_LIM) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            GAP:     state_d = REQ;
            default: state_d = IDLE;
        endcase
        if (state_d == REQ) begin
            mem_ad_d    = ad_d + {30'd0, k_d};
            mem_wdata_d = din_d[{k_d, 3'b000} +: 8];
        end
        mem_req_d = state_d == REQ;
        mem_we_d  = state_d == REQ && cmd_d == CMD_WR;
        ready_d   = state_d == RESP;
        busy_d    = state_d != IDLE;
    end

endmodule

// File: tb/tb_memctrl.sv
// tb_memctrl: directed vector table plus reset, back-to-back and timeout sequences
module tb_memctrl;
    import memctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    memctrl_if bus();

    memctrl #(.ACK_TIMEOUT(4), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cmd;
        logic [1:0]  size;
        logic [31:0] ad;
        logic [31:0] din;
        logic [31:0] rdata;
        int          wt;
        int          stall;
        logic [31:0] exp_dout;
        int          exp_cyc;
        logic        exp_err;
        int          exp_reqs;
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " ready"}, {31'd0, bus.ready}, 32'd0);
        chk({tag, " err"}, {31'd0, bus.err}, 32'd0);
        chk({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, " mem_req"}, {31'd0, bus.mem_req}, 32'd0);
        chk({tag, " mem_we"}, {31'd0, bus.mem_we}, 32'd0);
        chk({tag, " mem_ad"}, bus.mem_ad, 32'd0);
        chk({tag, " mem_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
        chk({tag, " dout"}, bus.dout, 32'd0);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int   cyc, beat, w, reqs;
        logic seen;
        string t;
        t = $sformatf("v%0d", i);
        @(negedge clk);
        bus.en   = 1'b1;
        bus.cmd  = v.cmd;
        bus.size = v.size;
        bus.ad   = v.ad;
        bus.din  = v.din;
        @(negedge clk);
        bus.en = 1'b0;
        cyc = 1; beat = 0; w = 0; reqs = 0; seen = 1'b0;
        while (!seen && cyc <= 40) begin
            if (bus.ready) begin
                seen = 1'b1;
            end else begin
                if (bus.mem_req) begin
                    reqs++;
                    if (w == 0) begin
                        chk({t, " mem_ad"}, bus.mem_ad, v.ad + 32'(beat));
                        chk({t, " mem_we"}, {31'd0, bus.mem_we}, {31'd0, v.cmd});
                        if (v.cmd == CMD_WR) chk({t, " mem_wdata"}, {24'd0, bus.mem_wdata}, {24'd0, v.din[8*beat +: 8]});
                    end
                    if (beat != v.stall && w == v.wt) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = v.rdata[8*beat +: 8];
                        beat++;
                        w = 0;
                    end else begin
                        w++;
                    end
                end
                @(negedge clk);
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 8'hEE;
                cyc++;
            end
        end
        chk({t, " ready seen"}, {31'd0, seen}, 32'd1);
        chk({t, " ready cycle"}, 32'(cyc), 32'(v.exp_cyc));
        chk({t, " err"}, {31'd0, bus.err}, {31'd0, v.exp_err});
        chk({t, " dout"}, bus.dout, v.exp_dout);
        chk({t, " req cycles"}, 32'(reqs), 32'(v.exp_reqs));
        chk({t, " mem_req in resp"}, {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
        chk({t, " ready pulse width"}, {31'd0, bus.ready}, 32'd0);
        chk({t, " idle busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int   pulses, first, second;
        logic switched, rdy;
        bus.en = 1'b0; bus.cmd = CMD_RD; bus.size = SZ_B; bus.ad = '0; bus.din = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 8'hEE;

        vecs[0] = '{CMD_RD, SZ_W,  32'h0000_0100, 32'h0,         32'h4433_2211, 0, 9, 32'h4433_2211, 8,  1'b0, 4};
        vecs[1] = '{CMD_RD, SZ_B,  32'h0000_0007, 32'h0,         32'hAABB_CCF0, 3, 9, 32'h0000_00F0, 5,  1'b0, 4};
        vecs[2] = '{CMD_WR, SZ_H,  32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h1234_5678, 0, 9, 32'h0000_00F0, 4,  1'b0, 2};
        vecs[3] = '{CMD_WR, SZ_W,  32'h0000_0020, 32'h0102_0304, 32'h0,         1, 9, 32'h0000_00F0, 12, 1'b0, 8};
        vecs[4] = '{CMD_RD, SZ_H,  32'h0000_0003, 32'h0,         32'hFFFF_A55A, 0, 9, 32'h0000_A55A, 4,  1'b0, 2};
        vecs[5] = '{CMD_RD, 2'b11, 32'h0000_0010, 32'h0,         32'h8765_4321, 0, 9, 32'h8765_4321, 8,  1'b0, 4};
        vecs[6] = '{CMD_RD, SZ_W,  32'h0000_0200, 32'h0,         32'hCCBB_AA99, 0, 1, 32'h0000_0099, 7,  1'b1, 5};
        vecs[7] = '{CMD_RD, SZ_B,  32'h0000_0040, 32'h0,         32'h0000_005A, 2, 9, 32'h0000_005A, 4,  1'b0, 3};

        repeat (2) @(negedge clk);
        chk("in reset mem_req", {31'd0, bus.mem_req}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_zero("post reset");

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        @(negedge clk);
        bus.en = 1'b1; bus.cmd = CMD_RD; bus.size = SZ_W; bus.ad = 32'h100;
        @(negedge clk);
        bus.en = 1'b0;
        for (int c = 1; c < 5; c++) begin
            bus.mem_ack   = bus.mem_req;
            bus.mem_rdata = 8'h77;
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        chk("pre rst mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("pre rst mem_ad", bus.mem_ad, 32'h102);
        rst = 1'b1;
        #1;
        chk("async rst mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("async rst busy", {31'd0, bus.busy}, 32'd0);
        rdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.ready) rdy = 1'b1;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.ready) rdy = 1'b1;
        end
        chk("no ready after rst", {31'd0, rdy}, 32'd0);
        check_zero("mid rst");

        @(negedge clk);
        bus.en = 1'b1; bus.cmd = CMD_RD; bus.size = SZ_W; bus.ad = 32'h300;
        pulses = 0; first = 0; second = 0; switched = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.busy && !switched) begin
                bus.size = SZ_B; bus.ad = 32'h55; switched = 1'b1;
            end
            if (bus.ready) begin
                pulses++;
                if (first == 0) begin
                    first = c;
                    chk("b2b word dout", bus.dout, 32'h0302_0100);
                end else begin
                    second = c;
                    bus.en = 1'b0;
                end
            end
            if (first != 0 && c == first + 1) begin
                chk("b2b idle busy", {31'd0, bus.busy}, 32'd0);
                chk("b2b idle mem_req", {31'd0, bus.mem_req}, 32'd0);
            end
            if (first != 0 && c == first + 2) begin
                chk("b2b 2nd mem_req", {31'd0, bus.mem_req}, 32'd1);
                chk("b2b 2nd mem_ad", bus.mem_ad, 32'h55);
            end
            bus.mem_ack   = bus.mem_req;
            bus.mem_rdata = bus.mem_ad[7:0];
        end
        bus.en = 1'b0;
        bus.mem_ack = 1'b0;
        chk("b2b first ready", 32'(first), 32'd8);
        chk("b2b second ready", 32'(second), 32'd11);
        chk("b2b pulses", 32'(pulses), 32'd2);
        chk("b2b byte dout", bus.dout, 32'h0000_0055);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
